// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and default latencies for the pipeline hazard unit.
//   mdu_state_t  : MDU occupancy FSM states (IDLE, BUSY, DONE)
//   MUL_LAT_DEF  : default cycles a MUL occupies Execute
//   DIV_LAT_DEF  : default cycles a DIV/REM occupies Execute
//   CNT_W_DEF    : default width of the MDU countdown counter
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 33;
  localparam int CNT_W_DEF   = 6;

endpackage

// File: rtl/mdu_stall_fsm.sv
// mdu_stall_fsm
//   Tracks how long a multi-cycle MUL/DIV occupies Execute.
//   Ports:
//     clk    in   core clock
//     reset  in   synchronous, active-low reset
//     start  in   MUL/DIV entering Execute (1-cycle pulse)
//     div    in   1=DIV/REM, 0=MUL; qualified by start
//     branch in   taken branch in Execute; squashes a coincident start
//     busy   out  pipe must be held this cycle (start cycle or BUSY)
//     state  out  current FSM state, for debug/checkers
//   Protocol: a start is accepted in IDLE or DONE when no branch is taken
//   that cycle. An accepted op occupies Execute for LAT cycles: the start
//   cycle, LAT-2 BUSY cycles, and one DONE cycle in which the result is valid.
//   Starts seen while BUSY are ignored because the instruction is frozen.
module mdu_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       div,
  input  logic       branch,
  output logic       busy,
  output mdu_state_t state
);

  // Number of BUSY cycles between the start cycle and the DONE cycle.
  localparam logic [CNT_W-1:0] MUL_RUN = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_RUN = CNT_W'(DIV_LAT - 2);

  mdu_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] run_len;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt holds the BUSY cycles still to go, including the current one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    run_len    = div ? DIV_RUN : MUL_RUN;
    case (state)
      BUSY: begin
        busy = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        if (start && !branch) begin
          busy = 1'b1;
          if (run_len == '0) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = run_len;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Stall/flush controller for the 5-stage RV32 pipeline: load-use stalls,
//   branch/jump flushes and holding the pipe during multi-cycle MUL/DIV.
//   Ports:
//     clk, reset         core clock; synchronous active-low reset
//     rs1_D, rs2_D       Decode source registers
//     rd_E, mem_read_E   Execute destination register / load flag
//     pc_src_E           taken branch/jump resolved in Execute
//     mdu_start_E        MUL/DIV entering Execute (1-cycle pulse)
//     mdu_div_E          1=DIV/REM, 0=MUL
//     stall_F/D/E        hold PC, F/D and D/E registers
//     flush_D/E          clear F/D and D/E registers
//     mdu_busy/mdu_done  MDU in progress / result valid this cycle
//     stall_cnt          cycles with stall_F=1
//     flush_cnt          cycles with flush_D=1
//   Build option: define HAZARD_PERF_CNT_EN to implement the two performance
//   counters; otherwise they are tied to zero and no counter flops exist.
//   All outputs are forced low while reset is asserted.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rd_E,
  input  logic        mem_read_E,
  input  logic        pc_src_E,
  input  logic        mdu_start_E,
  input  logic        mdu_div_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        flush_D,
  output logic        flush_E,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic       load_use;
  logic       fsm_busy;
  mdu_state_t mdu_state;

  mdu_stall_fsm #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_fsm (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start_E),
    .div    (mdu_div_E),
    .branch (pc_src_E),
    .busy   (fsm_busy),
    .state  (mdu_state)
  );

  // x0 is hardwired to zero, so a load targeting it can never be a hazard.
  assign load_use = mem_read_E && (rd_E != 5'd0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Priority: MDU hold > branch flush > load-use stall. While the MDU holds
  // the pipe the Execute instruction is frozen, so its branch/load state is
  // not acted on. A branch squashes a coincident MDU start (fsm_busy low).
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    if (reset) begin
      if (fsm_busy) begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_E  = 1'b1;
        mdu_busy = 1'b1;
      end else if (pc_src_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
      mdu_done = (mdu_state == DONE);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_F) stall_q <= stall_q + 32'd1;
      if (flush_D) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = reset ? stall_q : 32'd0;
  assign flush_cnt = reset ? flush_q : 32'd0;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
